// File: rtl/vmod1_capture_if.sv
// Local-bus bundle for vmod1_capture: write strobe, address and data in; read data out.
interface vmod1_capture_if;
  logic [31:0] lb_data;
  logic [14:0] lb_addr;
  logic        lb_write;
  logic [31:0] lb_rdata;

  modport master (output lb_data, lb_addr, lb_write, input  lb_rdata);
  modport slave  (input  lb_data, lb_addr, lb_write, output lb_rdata);
endinterface

// File: rtl/vmod1_capture.sv
// Diagnostic capture behind the cavity emulator: sticky clip flags plus a
// pre/post-trigger circular snapshot of field/forward/reflect, read over the local bus.
module vmod1_capture #(
  parameter int unsigned aw = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stb,
  input  logic signed [15:0] a_field,
  input  logic signed [15:0] a_forward,
  input  logic signed [15:0] a_reflect,
  input  logic [7:0]         clips,
  vmod1_capture_if.slave     lb,
  output logic               irq
);
  localparam int unsigned D = 1 << aw;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FILL  = 3'd1;
  localparam logic [2:0] ARMED = 3'd2;
  localparam logic [2:0] POST  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    r_state;
  logic [aw-1:0] r_wptr;
  logic [aw-1:0] r_fill;
  logic [aw-1:0] r_cnt;
  logic [aw-1:0] r_post;
  logic [aw-1:0] r_trig_ptr;
  logic [7:0]    r_sticky;
  logic [7:0]    r_mask;
  logic          r_pending;

  logic [15:0]   r_mem_f [D];
  logic [15:0]   r_mem_w [D];
  logic [15:0]   r_mem_r [D];
  logic [15:0]   r_q_f;
  logic [15:0]   r_q_w;
  logic [15:0]   r_q_r;
  logic          r_rd_buf;
  logic [1:0]    r_rd_ch;
  logic [31:0]   r_rd_reg;

  logic          w_reg_wr;
  logic          w_ctrl_wr;
  logic          w_arm;
  logic          w_swtrig;
  logic          w_clr;
  logic          w_we;
  logic          w_trig;
  logic          w_pend_nxt;
  logic [aw:0]   w_fill_inc;
  logic [aw:0]   w_pre;
  logic [aw-1:0] w_raddr;
  logic [31:0]   w_buf_data;
  logic          w_unused;

  assign w_reg_wr   = lb.lb_write && !lb.lb_addr[14];
  assign w_ctrl_wr  = w_reg_wr && (lb.lb_addr[1:0] == 2'd0);
  assign w_arm      = w_ctrl_wr && lb.lb_data[0];
  assign w_swtrig   = w_ctrl_wr && lb.lb_data[1];
  assign w_clr      = w_ctrl_wr && lb.lb_data[2];
  assign w_we       = stb && !w_arm &&
                      ((r_state == FILL) || (r_state == ARMED) || (r_state == POST));
  assign w_trig     = (r_state == ARMED) && stb && (r_pending || (|(clips & r_mask)));
  assign w_fill_inc = {1'b0, r_fill} + 1'b1;
  assign w_pre      = (aw+1)'(D - 1) - {1'b0, r_post};
  assign w_raddr    = r_wptr + lb.lb_addr[aw-1:0];
  assign irq        = (r_state == DONE);
  assign w_unused   = ^{lb.lb_data, lb.lb_addr};

  // ARM clears pending before a same-write SWTRIG sets it again.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_arm || w_trig) w_pend_nxt = 1'b0;
    if (w_swtrig)        w_pend_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_fill     <= '0;
      r_cnt      <= '0;
      r_post     <= '0;
      r_trig_ptr <= '0;
      r_sticky   <= '0;
      r_mask     <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_sticky  <= (w_clr ? '0 : r_sticky) | clips;
      r_pending <= w_pend_nxt;
      if (w_reg_wr && (lb.lb_addr[1:0] == 2'd1)) r_mask <= lb.lb_data[7:0];
      if (w_reg_wr && (lb.lb_addr[1:0] == 2'd2)) r_post <= lb.lb_data[aw-1:0];
      if (w_arm) begin
        r_state <= FILL;
        r_wptr  <= '0;
        r_fill  <= '0;
      end else begin
        if (w_we) r_wptr <= r_wptr + 1'b1;
        case (r_state)
          FILL: if (stb) begin
            r_fill <= r_fill + 1'b1;
            if (w_fill_inc >= w_pre) r_state <= ARMED;
          end
          ARMED: if (w_trig) begin
            r_trig_ptr <= r_wptr;
            r_cnt      <= r_post;
            r_state    <= (r_post == '0) ? DONE : POST;
          end
          POST: if (stb) begin
            if (r_cnt == aw'(1)) r_state <= DONE;
            else                 r_cnt   <= r_cnt - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem_f[r_wptr] <= a_field;
      r_mem_w[r_wptr] <= a_forward;
      r_mem_r[r_wptr] <= a_reflect;
    end
    r_q_f <= r_mem_f[w_raddr];
    r_q_w <= r_mem_w[w_raddr];
    r_q_r <= r_mem_r[w_raddr];
  end

  always_comb begin
    w_buf_data = '0;
    case (r_rd_ch)
      2'd0:    w_buf_data = {{16{r_q_f[15]}}, r_q_f};
      2'd1:    w_buf_data = {{16{r_q_w[15]}}, r_q_w};
      2'd2:    w_buf_data = {{16{r_q_r[15]}}, r_q_r};
      default: w_buf_data = '0;
    endcase
  end

  // Register reads are delayed through the same two stages as the RAM path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_buf    <= 1'b0;
      r_rd_ch     <= '0;
      r_rd_reg    <= '0;
      lb.lb_rdata <= '0;
    end else begin
      r_rd_buf <= lb.lb_addr[14];
      r_rd_ch  <= lb.lb_addr[aw+1:aw];
      case (lb.lb_addr[1:0])
        2'd0:    r_rd_reg <= {20'b0, r_state, 1'b0, r_sticky};
        2'd1:    r_rd_reg <= 32'(r_trig_ptr);
        2'd2:    r_rd_reg <= 32'(r_post);
        default: r_rd_reg <= '0;
      endcase
      lb.lb_rdata <= r_rd_buf ? w_buf_data : r_rd_reg;
    end
  end
endmodule

// File: tb/tb_vmod1_capture.sv
// Randomized scoreboard bench for vmod1_capture with a sample-list reference model.
module tb_vmod1_capture;
  localparam int unsigned AW = 4;
  localparam int D = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic [15:0] a_field = '0;
  logic [15:0] a_forward = '0;
  logic [15:0] a_reflect = '0;
  logic [7:0]  clips = '0;
  logic        irq;

  vmod1_capture_if bus ();

  vmod1_capture #(.aw(AW)) dut (
    .clk(clk), .rst_n(rst_n), .stb(stb),
    .a_field(a_field), .a_forward(a_forward), .a_reflect(a_reflect),
    .clips(clips), .lb(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        rd_req = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  // Model: list of samples written since ARM, index of trigger sample, done flag.
  logic [47:0] smp[$];
  int          m_cnt, m_trig, m_post;
  bit          m_active, m_done, m_pend;
  logic [7:0]  m_mask, m_sticky;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int thresh();
    int t = D - 1 - m_post;
    return (t > 1) ? t : 1;
  endfunction

  function automatic logic [2:0] m_state();
    if (m_done)       return 3'd4;
    if (!m_active)    return 3'd0;
    if (m_trig >= 0)  return 3'd3;
    if (m_cnt >= thresh()) return 3'd2;
    return 3'd1;
  endfunction

  function automatic logic [31:0] reg0_exp();
    return {20'b0, m_state(), 1'b0, m_sticky};
  endfunction

  function automatic logic [31:0] buf_exp(input int ch, input int i);
    logic [47:0] s;
    logic [15:0] v;
    if (ch == 3 || smp.size() < D) return '0;
    s = smp[smp.size() - D + i];
    v = (ch == 0) ? s[47:32] : (ch == 1) ? s[31:16] : s[15:0];
    return {{16{v[15]}}, v};
  endfunction

  task automatic model_reset();
    smp.delete();
    m_cnt = 0; m_trig = -1; m_post = 0;
    m_active = 0; m_done = 0; m_pend = 0;
    m_mask = '0; m_sticky = '0;
  endtask

  task automatic model_step();
    logic [31:0] d = bus.lb_data;
    bit wr = bus.lb_write && !bus.lb_addr[14];
    int a = int'(bus.lb_addr[1:0]);
    int idx;
    m_sticky = ((wr && a == 0 && d[2]) ? 8'h00 : m_sticky) | clips;
    if (wr && a == 0 && d[0]) begin
      smp.delete();
      m_cnt = 0; m_trig = -1; m_active = 1; m_done = 0; m_pend = 0;
    end else if (m_active && stb) begin
      idx = m_cnt;
      smp.push_back({a_field, a_forward, a_reflect});
      m_cnt++;
      if (m_trig < 0) begin
        if (idx >= thresh() && (m_pend || (clips & m_mask) != 0)) begin
          m_trig = idx;
          m_pend = 0;
          if (m_post == 0) begin m_done = 1; m_active = 0; end
        end
      end else if (idx - m_trig == m_post) begin
        m_done = 1; m_active = 0;
      end
    end
    if (wr && a == 0 && d[1]) m_pend = 1;
    if (wr && a == 1) m_mask = d[7:0];
    if (wr && a == 2) m_post = int'(d[AW-1:0]);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    bus.lb_write = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic rand_sample();
    a_field   = 16'($urandom);
    a_forward = 16'($urandom);
    a_reflect = 16'($urandom);
  endtask

  task automatic lb_wr(input int a, input logic [31:0] d);
    bus.lb_addr = 15'(a); bus.lb_data = d; bus.lb_write = 1'b1;
    tick();
  endtask

  task automatic set_swtrig();
    bus.lb_addr = '0; bus.lb_data = 32'd2; bus.lb_write = 1'b1;
  endtask

  task automatic lb_rd(input int a, input logic [31:0] e, input string nm);
    bus.lb_addr = 15'(a); bus.lb_write = 1'b0; rd_req = 1'b1;
    exp_q.push_back(e); name_q.push_back(nm);
    tick();
  endtask

  task automatic rd_reg0(input string nm);
    lb_rd(0, reg0_exp(), nm);
  endtask

  task automatic rd_buf(input int ch, input int i, input string nm);
    lb_rd(16384 + ch * D + i, buf_exp(ch, i), nm);
  endtask

  task automatic timeout_check(input string nm);
    checks++;
    if (!m_done) begin
      errors++;
      $display("FAIL %s: capture not complete within cycle budget, required done", nm);
    end
  endtask

  task automatic async_reset();
    model_step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_irq", {31'b0, irq}, 32'd0);
    check("arst_rdata", bus.lb_rdata, 32'd0);
    repeat (2) @(negedge clk);
    check("arst_rdata_hold", bus.lb_rdata, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic v1, v2;
    v1 = 1'b0; v2 = 1'b0;
    forever begin
      @(posedge clk);
      v2 = v1; v1 = rd_req;
      #1;
      if (!rst_n) begin
        v1 = 1'b0; v2 = 1'b0;
      end else begin
        check("irq", {31'b0, irq}, {31'b0, m_done});
        if (v2) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_underflow: got %h, expected no read", bus.lb_rdata);
          end else begin
            check(name_q.pop_front(), bus.lb_rdata, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit hit, required $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit sw;
    int pv;
    bus.lb_addr = '0; bus.lb_data = '0; bus.lb_write = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_rdata", bus.lb_rdata, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    lb_rd(0, 32'h0, "reset_reg0");
    lb_rd(1, 32'h0, "reset_trigptr");
    lb_rd(2, 32'h0, "reset_post");

    // sticky clip flags
    clips = 8'h02; tick(); clips = 8'h00; tick();
    rd_reg0("sticky_set");
    clips = 8'h02; lb_wr(0, 32'd4); clips = 8'h00; tick();
    rd_reg0("sticky_clr_hold");
    lb_wr(0, 32'd4); tick();
    rd_reg0("sticky_clr");

    // ramp capture, post=4, software trigger lands on sample 20
    stb = 1'b0;
    lb_wr(2, 32'd4); lb_wr(0, 32'd1);
    for (int k = 0; k < 60 && !m_done; k++) begin
      stb = 1'b1; rand_sample(); a_field = 16'(k);
      if (k == 19) set_swtrig();
      tick();
    end
    timeout_check("ramp_done");
    for (int i = 0; i < D; i++) rd_buf(0, i, "ramp_field");
    lb_rd(16384 + 11, 32'd20, "ramp_trig_sample");
    lb_rd(1, 32'd4, "ramp_trigptr");
    rd_reg0("ramp_state_done");
    lb_rd(2, 32'd4, "ramp_post");
    rd_buf(1, 3, "ramp_fwd"); rd_buf(2, 7, "ramp_refl"); rd_buf(3, 5, "ramp_ch3");

    // clip-mask trigger held from sample 3, post=0
    stb = 1'b0;
    lb_wr(1, 32'd1); lb_wr(2, 32'd0); lb_wr(0, 32'd1);
    for (int k = 0; k < 60 && !m_done; k++) begin
      stb = 1'b1; rand_sample(); clips = (k >= 3) ? 8'h01 : 8'h00;
      tick();
    end
    timeout_check("clip_done");
    rd_buf(0, 15, "clip_field_trig");
    rd_buf(1, 0, "clip_fwd_oldest");
    lb_rd(1, 32'd15, "clip_trigptr");
    rd_reg0("clip_state");
    clips = 8'h00;

    // strobe toggling, post=2
    stb = 1'b0;
    lb_wr(1, 32'd0); lb_wr(2, 32'd2); lb_wr(0, 32'd1);
    sw = 0;
    for (int k = 0; k < 200 && !m_done; k++) begin
      stb = (k % 2 == 0); rand_sample();
      if (!sw && m_cnt >= 14) begin set_swtrig(); sw = 1; end
      tick();
    end
    timeout_check("toggle_done");
    stb = 1'b0;
    for (int j = 0; j < 4; j++) begin
      int ch = $urandom_range(0, 2);
      rd_buf(ch, $urandom_range(0, D - 1), "toggle_buf");
    end
    lb_rd(1, 32'(m_trig % D), "toggle_trigptr");

    // re-ARM during POST, then asynchronous reset in ARMED
    lb_wr(2, 32'd3); lb_wr(0, 32'd1);
    sw = 0;
    for (int k = 0; k < 60 && m_trig < 0; k++) begin
      stb = 1'b1; rand_sample();
      if (!sw && m_cnt >= 12) begin set_swtrig(); sw = 1; end
      tick();
    end
    stb = 1'b0;
    lb_wr(0, 32'd1);
    rd_reg0("rearm_state");
    for (int k = 0; k < 20; k++) begin stb = 1'b1; rand_sample(); tick(); end
    stb = 1'b0;
    rd_reg0("rearm_pend_cleared");
    lb_wr(1, 32'hFF); lb_wr(2, 32'd5);
    async_reset();
    rd_reg0("arst_reg0");
    lb_rd(2, 32'd0, "arst_post");
    lb_wr(0, 32'd1);
    for (int k = 0; k < 20; k++) begin stb = 1'b1; clips = 8'hFF; rand_sample(); tick(); end
    stb = 1'b0;
    rd_reg0("arst_mask_cleared");
    clips = 8'h00;
    lb_wr(0, 32'd4);

    // randomized captures, including post = D-1 and post = 0
    for (int it = 0; it < 3; it++) begin
      pv = (it == 0) ? D - 1 : (it == 1) ? 0 : $urandom_range(1, D - 2);
      stb = 1'b0;
      lb_wr(2, 32'(pv)); lb_wr(1, 32'($urandom_range(1, 255))); lb_wr(0, 32'd1);
      for (int k = 0; k < 400 && !m_done; k++) begin
        stb = ($urandom_range(0, 9) < 7); rand_sample();
        clips = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h00;
        if ($urandom_range(0, 29) == 0) begin
          bus.lb_addr = '0; bus.lb_data = 32'(2 | ($urandom_range(0, 1) << 2)); bus.lb_write = 1'b1;
        end
        tick();
      end
      timeout_check("rand_done");
      stb = 1'b0; clips = 8'h00;
      for (int ch = 0; ch < 4; ch++)
        for (int i = 0; i < D; i++) rd_buf(ch, i, "rand_buf");
      lb_rd(1, 32'(m_trig % D), "rand_trigptr");
      rd_reg0("rand_reg0");
      lb_rd(2, 32'(pv), "rand_post");
    end

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vmod1_capture.md
Name: vmod1_capture

Overview:
- Diagnostic capture stage directly downstream of the single-cavity emulator.
- Consumes the three emulated ADC streams (field, forward, reflect) and the 8-bit clip status.
- Latches clip bits as sticky flags, because the emulator leaves latching, reporting and clearing to its caller.
- Records a pre/post-trigger circular snapshot of all three ADC streams and returns flags and snapshot over the local bus, in chronological order.

Parameters:
- aw, 10: buffer address width; depth D = 2^aw samples per channel.

Ports:
- clk  in  1  system clock; also the local-bus clock.
- rst_n  in  1  asynchronous, active-low reset.
- stb  in  1  sample strobe; one buffer entry is written per stb=1 cycle while capturing.
- a_field  in  16  signed cavity-field ADC sample.
- a_forward  in  16  signed forward ADC sample.
- a_reflect  in  16  signed reflected ADC sample.
- clips  in  8  emulator clip status, level, per bit.
- lb_data  in  32  local-bus write data.
- lb_addr  in  15  local-bus address.
- lb_write  in  1  single-cycle write strobe.
- lb_rdata  out  32  local-bus read data.
- irq  out  1  high while state is DONE.

Behaviour:

Reset (rst_n=0, asynchronous):
- State IDLE; wptr, fill count, post count and pending trigger = 0.
- sticky=0, mask=0, post=0.
- lb_rdata=0, irq=0.
- Reset mid-capture discards the capture.

Register map (lb_addr[14]=0, decode lb_addr[1:0]):
- Write 0, control:
  - bit0 ARM: enter FILL, clear wptr, fill count and pending trigger.
  - bit1 SWTRIG: set pending trigger.
  - bit2 CLR: clear sticky.
- Write 1: mask <= lb_data[7:0].
- Write 2: post <= lb_data[aw-1:0].
- Read 0: {20'b0, state[2:0], 1'b0, sticky[7:0]}.
- Read 1: trigger pointer.
- Read 2: post.
- State encoding: IDLE=0, FILL=1, ARMED=2, POST=3, DONE=4.

Buffer read (lb_addr[14]=1):
- Channel select lb_addr[aw+1:aw]: 0=field, 1=forward, 2=reflect, 3 reads 0.
- Index i = lb_addr[aw-1:0]; physical address = (wptr_end + i) mod D, so i=0 is the oldest sample.
- Data returned sign-extended to 32 bits.

Read latency:
- lb_rdata is valid exactly 2 clk after lb_addr is presented (registered RAM, then output register), for both register and buffer reads.
- Reads have no side effects.

Sticky clips:
- sticky <= (sticky | clips) every cycle; CLR applies before the OR.
- CLR in the same cycle as a clip bit high leaves that bit set.

Capture state machine (all writes happen only on stb=1 cycles):
- IDLE: no writes. ARM -> FILL.
- FILL:
  - Write sample at wptr, wptr++ (wraps mod D), fill++.
  - When fill reaches D-1-post -> ARMED. If post = D-1, go ARMED on the first stb.
  - Triggers arriving during FILL set pending but are not acted on until ARMED.
- ARMED:
  - Write sample.
  - Trigger condition: pending, or |(clips & mask).
  - On a stb cycle with the trigger condition true: record the trigger pointer = wptr of this sample, clear pending, load post counter = post.
  - If post=0 -> DONE, else -> POST.
- POST:
  - Write sample, decrement counter.
  - When the counter reaches 1 and this write completes -> DONE.
  - Triggers are ignored.
- DONE:
  - No writes; wptr_end = wptr; irq=1.
  - ARM -> FILL, which restarts the capture.
- ARM in any state restarts into FILL. ARM and SWTRIG in the same write: ARM clears pending first, then SWTRIG sets it.

Snapshot layout:
- Total samples = (D-1-post) pre-trigger + 1 trigger + post = D.
- The trigger sample appears at index D-1-post.

Writes while stb=0 in capturing states are skipped, and counters hold.

Test Plan (aw=4, D=16):
- Reset, then read addr 0 -> 0x00000000; lb_rdata=0 during reset; irq=0.
- clips=0x02 for 1 cycle, then 0 -> read 0 gives sticky=0x02; write CLR with clips=0x02 asserted -> sticky remains 0x02; CLR with clips=0 -> 0x00.
- stb=1 always, a_field = ramp starting at 0 from ARM cycle, post=4, SWTRIG at sample 20 -> DONE after sample 24, irq=1; buffer field index 0..15 reads 9..24 and index 11 = 20.
- mask=0x01, post=0, clips[0] asserted during FILL (sample 3) and held -> trigger at first ARMED sample (15); field index 15 = 15; DONE one cycle later.
- stb toggling 1/0, post=2, SWTRIG -> counters advance only on stb cycles; DONE after exactly 2 further strobes.
- ARM during POST -> state FILL, pending cleared, irq=0; rst_n low during ARMED -> state IDLE immediately (asynchronous), mask/post reset to 0.
